// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if
//   Carries the writeback request bundle and the registered write-port bundle
//   between the three writeback sources and the register-file write arbiter.
//   master : the requester side (drives requests, observes grant and write port)
//   slave  : the arbiter (returns grant, drives the registered write port)
//   Signals:
//     req_valid [2:0]          per-source request (0 ALU, 1 load, 2 link)
//     req_dr    [8:0]          destination registers, 3 bits per source
//     req_data  [3*DATA_W-1:0] write data, DATA_W bits per source
//     req_ready [2:0]          one-hot combinational grant
//     wr_en     [7:0]          one-hot registered row write enable
//     wr_dr     [2:0]          registered destination register
//     wr_data   [DATA_W-1:0]   registered write data
interface regfile_write_arbiter_if #(
  parameter int DATA_W = 16
);
  logic [2:0]          req_valid;
  logic [8:0]          req_dr;
  logic [3*DATA_W-1:0] req_data;
  logic [2:0]          req_ready;
  logic [7:0]          wr_en;
  logic [2:0]          wr_dr;
  logic [DATA_W-1:0]   wr_data;

  modport master (
    output req_valid, req_dr, req_data,
    input  req_ready, wr_en, wr_dr, wr_data
  );

  modport slave (
    input  req_valid, req_dr, req_data,
    output req_ready, wr_en, wr_dr, wr_data
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Round-robin arbiter sharing the LC-3 register file's single write port
//   between the ALU, memory-load and R7-link writeback sources. One source is
//   granted per cycle (combinational one-hot req_ready); the winner's
//   destination and data are registered and presented for one cycle, with the
//   destination decoded into one-hot row write enables.
//   Optional feature macro: RFWR_FWD_EN compiles in write-to-read forwarding
//   on the two read ports; otherwise read data passes straight through.
//   Ports:
//     clk, reset            clock, synchronous active-high reset
//     bus (slave)           request/grant and registered write-port bundle
//     rf_hold               freezes all grants while high
//     rd_addr_a/b           register-file read addresses
//     rd_data_a/b           register-file read data
//     fwd_data_a/b          read data after optional forwarding
//     conflict_cnt          saturating count of cycles with >=2 requests
module regfile_write_arbiter #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  regfile_write_arbiter_if.slave      bus,
  input  logic                        rf_hold,
  input  logic [2:0]                  rd_addr_a,
  input  logic [2:0]                  rd_addr_b,
  input  logic [DATA_W-1:0]           rd_data_a,
  input  logic [DATA_W-1:0]           rd_data_b,
  output logic [DATA_W-1:0]           fwd_data_a,
  output logic [DATA_W-1:0]           fwd_data_b,
  output logic [CNT_W-1:0]            conflict_cnt
);

  // Next source index in round-robin order (0 -> 1 -> 2 -> 0).
  function automatic logic [1:0] rr_next(input logic [1:0] cur);
    return (cur == 2'd2) ? 2'd0 : cur + 2'd1;
  endfunction

  function automatic logic [7:0] dec3to8(input logic [2:0] dr);
    return 8'b0000_0001 << dr;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                input logic             en);
    logic [CNT_W-1:0] max_val;
    max_val = '1;
    if (en && (cnt != max_val)) return cnt + 1'b1;
    return cnt;
  endfunction

  logic [1:0]        last_p1;
  logic [7:0]        wr_en_p1;
  logic [2:0]        wr_dr_p1;
  logic [DATA_W-1:0] wr_data_p1;
  logic [CNT_W-1:0]  cnt_p1;

  logic [1:0]        cand_p0;
  logic [1:0]        gidx_p0;
  logic              found_p0;
  logic              vld_p0;
  logic [2:0]        gnt_p0;
  logic [2:0]        gnt_dr_p0;
  logic [DATA_W-1:0] gnt_data_p0;
  logic              multi_p0;

  // Stage p0: combinational round-robin search starting after the last winner.
  always_comb begin
    cand_p0  = rr_next(last_p1);
    gidx_p0  = 2'd0;
    found_p0 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (!found_p0 && bus.req_valid[cand_p0]) begin
        found_p0 = 1'b1;
        gidx_p0  = cand_p0;
      end
      cand_p0 = rr_next(cand_p0);
    end
  end

  assign vld_p0      = found_p0 && !reset && !rf_hold;
  assign gnt_p0      = vld_p0 ? (3'b001 << gidx_p0) : 3'b000;
  assign gnt_dr_p0   = bus.req_dr[3*gidx_p0 +: 3];
  assign gnt_data_p0 = bus.req_data[DATA_W*gidx_p0 +: DATA_W];
  // More than one requester this cycle, independent of rf_hold.
  assign multi_p0    = (bus.req_valid[0] & bus.req_valid[1]) |
                       (bus.req_valid[0] & bus.req_valid[2]) |
                       (bus.req_valid[1] & bus.req_valid[2]);

  assign bus.req_ready = gnt_p0;

  // Stage p1: registered write port, round-robin pointer and conflict counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_p1    <= 2'd2;
      wr_en_p1   <= '0;
      wr_dr_p1   <= '0;
      wr_data_p1 <= '0;
      cnt_p1     <= '0;
    end else begin
      cnt_p1 <= sat_inc(cnt_p1, multi_p0);
      if (vld_p0) begin
        last_p1    <= gidx_p0;
        wr_en_p1   <= dec3to8(gnt_dr_p0);
        wr_dr_p1   <= gnt_dr_p0;
        wr_data_p1 <= gnt_data_p0;
      end else begin
        wr_en_p1   <= '0;
      end
    end
  end

  assign bus.wr_en   = wr_en_p1;
  assign bus.wr_dr   = wr_dr_p1;
  assign bus.wr_data = wr_data_p1;
  assign conflict_cnt = cnt_p1;

`ifdef RFWR_FWD_EN
  // Bypass the in-flight write so a same-cycle read sees the new value.
  assign fwd_data_a = ((wr_en_p1 != 8'd0) && (wr_dr_p1 == rd_addr_a)) ? wr_data_p1 : rd_data_a;
  assign fwd_data_b = ((wr_en_p1 != 8'd0) && (wr_dr_p1 == rd_addr_b)) ? wr_data_p1 : rd_data_b;
`else
  assign fwd_data_a = rd_data_a;
  assign fwd_data_b = rd_data_b;
`endif

endmodule
